// File: rtl/ifu_pkg.sv
// ifu_pkg: shared types and constants for the instruction fetch unit.
//   state_e        - fetch state machine encoding
//   ERR_*          - error codes carried with every queued instruction
//   fetch_entry_t  - one queue entry {inst, pc, err} at the default 32-bit widths
package ifu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  localparam logic [1:0] ERR_OK       = 2'd0;
  localparam logic [1:0] ERR_MISALIGN = 2'd1;
  localparam logic [1:0] ERR_FAULT    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned ILEN_DEF = 32;

  typedef struct packed {
    logic [ILEN_DEF-1:0] inst;
    logic [XLEN_DEF-1:0] pc;
    logic [1:0]          err;
  } fetch_entry_t;

endpackage

// File: rtl/ifu_queue.sv
// ifu_queue: small in-order FIFO of fetch entries.
//   clk, rst         - clock, asynchronous active-high reset
//   push, push_data  - write one entry at the tail
//   pop              - remove the head entry (caller guarantees non-empty)
//   clear            - drop all entries; wins over push and pop
//   head             - head entry, zero while empty
//   empty, full      - occupancy flags
//   count            - number of stored entries, 0..DEPTH
module ifu_queue
  import ifu_pkg::*;
#(
  parameter int unsigned DEPTH   = 2,
  parameter type         entry_t = fetch_entry_t
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  entry_t                 push_data,
  input  logic                   pop,
  input  logic                   clear,
  output entry_t                 head,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PW = $clog2(DEPTH);

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW:0]     count_q, count_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap by plain overflow.
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + (PW+1)'(1);
        2'b01:   count_d = count_q - (PW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state is updated with non-blocking assignments only.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage has no reset; head is forced to zero while empty, so stale contents never leak.
  always_ff @(posedge clk) begin
    if (push && !clear) mem_q[wr_ptr_q] <= push_data;
  end

  assign empty = (count_q == '0);
  assign full  = (count_q == (PW+1)'(DEPTH));
  assign count = count_q;
  assign head  = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit with a variable-latency memory port.
//   clk, rst                        - clock, asynchronous active-high reset
//   pc, s_valid, s_ready            - upstream fetch address handshake
//   mem_req_valid/ready/addr        - memory read request
//   mem_rsp_valid/data/err          - memory response (always accepted)
//   flush                           - discard queue and any in-flight fetch
//   m_valid, m_ready                - downstream handshake for the head entry
//   inst, inst_pc, inst_err         - head instruction, its PC and error code
// At most one fetch is in flight; a pc is only accepted when a queue slot is
// free, so every response (or error entry) always has room.
module ifu_fetch
  import ifu_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ILEN    = 32,
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc,
  input  logic            s_valid,
  output logic            s_ready,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_rsp_valid,
  input  logic [ILEN-1:0] mem_rsp_data,
  input  logic            mem_rsp_err,
  input  logic            flush,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [ILEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic [1:0]      inst_err
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  // Same layout as fetch_entry_t, sized for this instance's widths.
  typedef struct packed {
    logic [ILEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic [1:0]      err;
  } entry_t;

  state_e          state_q, state_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic [TW-1:0]   cnt_q, cnt_d;

  logic            push, pop;
  entry_t          push_entry, head;
  logic            q_empty, q_full;
  logic [CW-1:0]   q_count;

  assign s_ready = (state_q == IDLE) && !flush && (q_count < CW'(DEPTH));
  assign m_valid = !q_empty && !flush;
  assign pop     = m_valid && m_ready;

  always_comb begin
    state_d    = state_q;
    req_pc_d   = req_pc_q;
    cnt_d      = cnt_q;
    push       = 1'b0;
    push_entry = '0;
    unique case (state_q)
      IDLE: begin
        if (s_valid && s_ready) begin
          req_pc_d = pc;
          if (pc[1:0] != 2'b00) begin
            // Misaligned: report immediately without touching memory.
            push           = 1'b1;
            push_entry.pc  = pc;
            push_entry.err = ERR_MISALIGN;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (mem_req_ready) begin
          cnt_d   = '0;
          // A flush racing an accepted request must still swallow its response.
          state_d = flush ? DRAIN : WAIT;
        end else if (flush) begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + TW'(1);
        if (mem_rsp_valid) begin
          state_d = IDLE;
          if (!flush) begin
            push            = 1'b1;
            push_entry.inst = mem_rsp_data;
            push_entry.pc   = req_pc_q;
            push_entry.err  = mem_rsp_err ? ERR_FAULT : ERR_OK;
          end
        end else if (flush) begin
          state_d = DRAIN;
        end else if (cnt_q == TW'(TIMEOUT)) begin
          push           = 1'b1;
          push_entry.pc  = req_pc_q;
          push_entry.err = ERR_TIMEOUT;
          state_d        = DRAIN;
        end
      end
      DRAIN: begin
        // The late response of an abandoned fetch is consumed here.
        if (mem_rsp_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      req_pc_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      req_pc_q <= req_pc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign mem_req_valid = (state_q == REQ);
  assign mem_req_addr  = req_pc_q;

  ifu_queue #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .clear     (flush),
    .head      (head),
    .empty     (q_empty),
    .full      (q_full),
    .count     (q_count)
  );

  assign inst     = head.inst;
  assign inst_pc  = head.pc;
  assign inst_err = head.err;

  // The credit rule reserves a slot before every accepted pc.
  assert property (@(posedge clk) disable iff (rst) !(push && q_full && !pop));

endmodule

// File: tb/tb_ifu_fetch.sv
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        s_valid;
  logic        s_ready;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        mem_rsp_err;
  logic        flush;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [1:0]  inst_err;

  int total = 0;
  int bad   = 0;

  ifu_fetch #(.XLEN(32), .ILEN(32), .DEPTH(2), .TIMEOUT(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .pc            (pc),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .mem_rsp_err   (mem_rsp_err),
    .flush         (flush),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .inst_err      (inst_err)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Aligned fetch with a one-cycle memory: accept, request, respond.
  task automatic fetch(input logic [31:0] a, input logic [31:0] d, input logic e);
    pc = a; s_valid = 1'b1;
    tick();
    s_valid = 1'b0; mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = d; mem_rsp_err = e;
    tick();
    mem_rsp_valid = 1'b0; mem_rsp_err = 1'b0; mem_rsp_data = '0;
  endtask

  task automatic pop_one();
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; pc = '0; s_valid = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    mem_rsp_data = '0; mem_rsp_err = 1'b0; flush = 1'b0; m_ready = 1'b0;
    tick(); tick();
    @(negedge clk);
    total++; if ({m_valid, mem_req_valid} !== 2'b00) begin bad++; $display("FAIL reset_valids: got %b want 00", {m_valid, mem_req_valid}); end
    total++; if ({inst, inst_pc, inst_err} !== 66'd0) begin bad++; $display("FAIL reset_head: got %h/%h/%0d want 0", inst, inst_pc, inst_err); end
    tick();
    rst = 1'b0;
    @(negedge clk);
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL reset_s_ready: got %b want 1", s_ready); end
    tick();
  endtask

  task automatic test_basic();
    pc = 32'h8000_0000; s_valid = 1'b1;
    @(negedge clk);
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL basic_accept: got %b want 1", s_ready); end
    tick();
    s_valid = 1'b0; mem_req_ready = 1'b1;
    @(negedge clk);
    total++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0000) begin bad++; $display("FAIL basic_req: got %b/%h want 1/80000000", mem_req_valid, mem_req_addr); end
    tick();
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0000_0413;
    @(negedge clk);
    total++; if (m_valid !== 1'b0 || mem_req_valid !== 1'b0) begin bad++; $display("FAIL basic_wait: got m_valid=%b req=%b want 0/0", m_valid, mem_req_valid); end
    tick();
    mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    @(negedge clk);
    total++; if ({m_valid, inst, inst_pc, inst_err} !== {1'b1, 32'h0000_0413, 32'h8000_0000, 2'd0}) begin bad++; $display("FAIL basic_head: got %b/%h/%h/%0d want 1/00000413/80000000/0", m_valid, inst, inst_pc, inst_err); end
    pop_one();
    @(negedge clk);
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL basic_pop: got %b want 0", m_valid); end
    tick();
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_pc [2];
    logic [31:0] exp_in [2];
    exp_pc[0] = 32'h4; exp_in[0] = 32'hA4;
    exp_pc[1] = 32'h8; exp_in[1] = 32'hA8;
    fetch(32'h0, 32'hA0, 1'b0);
    fetch(32'h4, 32'hA4, 1'b0);
    pc = 32'h8; s_valid = 1'b1;
    @(negedge clk);
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL bp_full_s_ready: got %b want 0", s_ready); end
    total++; if ({m_valid, inst_pc, inst} !== {1'b1, 32'h0, 32'hA0}) begin bad++; $display("FAIL bp_head0: got %b/%h/%h want 1/0/a0", m_valid, inst_pc, inst); end
    tick();
    m_ready = 1'b1;
    @(negedge clk);
    total++; if (s_ready !== 1'b0 || mem_req_valid !== 1'b0) begin bad++; $display("FAIL bp_hold: got s_ready=%b req=%b want 0/0", s_ready, mem_req_valid); end
    tick();
    m_ready = 1'b0;
    @(negedge clk);
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL bp_after_pop: got %b want 1", s_ready); end
    tick();
    s_valid = 1'b0; mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'hA8;
    tick();
    mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++; if ({m_valid, inst_pc, inst} !== {1'b1, exp_pc[i], exp_in[i]}) begin bad++; $display("FAIL bp_order%0d: got %b/%h/%h want 1/%h/%h", i, m_valid, inst_pc, inst, exp_pc[i], exp_in[i]); end
      pop_one();
    end
    @(negedge clk);
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL bp_drained: got %b want 0", m_valid); end
    tick();
  endtask

  task automatic test_misaligned();
    pc = 32'h8000_0002; s_valid = 1'b1;
    @(negedge clk);
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL mis_accept: got %b want 1", s_ready); end
    tick();
    s_valid = 1'b0;
    @(negedge clk);
    total++; if (mem_req_valid !== 1'b0) begin bad++; $display("FAIL mis_no_req: got %b want 0", mem_req_valid); end
    total++; if ({m_valid, inst, inst_pc, inst_err} !== {1'b1, 32'h0, 32'h8000_0002, 2'd1}) begin bad++; $display("FAIL mis_entry: got %b/%h/%h/%0d want 1/0/80000002/1", m_valid, inst, inst_pc, inst_err); end
    pop_one();
  endtask

  task automatic test_fault();
    fetch(32'h40, 32'hDEAD, 1'b1);
    @(negedge clk);
    total++; if ({m_valid, inst_pc, inst_err} !== {1'b1, 32'h40, 2'd2}) begin bad++; $display("FAIL fault_entry: got %b/%h/%0d want 1/40/2", m_valid, inst_pc, inst_err); end
    pop_one();
  endtask

  task automatic test_timeout();
    pc = 32'h200; s_valid = 1'b1;
    tick();
    s_valid = 1'b0; mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL to_early%0d: got %b want 0", i, m_valid); end
      tick();
    end
    @(negedge clk);
    total++; if ({m_valid, inst, inst_pc, inst_err} !== {1'b1, 32'h0, 32'h200, 2'd3}) begin bad++; $display("FAIL to_entry: got %b/%h/%h/%0d want 1/0/200/3", m_valid, inst, inst_pc, inst_err); end
    pop_one();
    @(negedge clk);
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL to_drain_s_ready: got %b want 0", s_ready); end
    repeat (9) tick();
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'hBAD;
    tick();
    mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    @(negedge clk);
    total++; if (m_valid !== 1'b0 || s_ready !== 1'b1) begin bad++; $display("FAIL to_late_drop: got m_valid=%b s_ready=%b want 0/1", m_valid, s_ready); end
    tick();
    fetch(32'h300, 32'h1234, 1'b0);
    @(negedge clk);
    total++; if ({m_valid, inst, inst_pc, inst_err} !== {1'b1, 32'h1234, 32'h300, 2'd0}) begin bad++; $display("FAIL to_next: got %b/%h/%h/%0d want 1/1234/300/0", m_valid, inst, inst_pc, inst_err); end
    pop_one();
  endtask

  task automatic test_flush_wait();
    pc = 32'h6; s_valid = 1'b1;
    tick();
    pc = 32'h500;
    tick();
    s_valid = 1'b0; mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    tick();
    flush = 1'b1;
    @(negedge clk);
    total++; if (m_valid !== 1'b0 || s_ready !== 1'b0) begin bad++; $display("FAIL fl_during: got m_valid=%b s_ready=%b want 0/0", m_valid, s_ready); end
    tick();
    flush = 1'b0;
    @(negedge clk);
    total++; if (m_valid !== 1'b0 || s_ready !== 1'b0) begin bad++; $display("FAIL fl_drain: got m_valid=%b s_ready=%b want 0/0", m_valid, s_ready); end
    tick(); tick();
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'hBEEF;
    tick();
    mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    @(negedge clk);
    total++; if (m_valid !== 1'b0 || s_ready !== 1'b1) begin bad++; $display("FAIL fl_dropped: got m_valid=%b s_ready=%b want 0/1", m_valid, s_ready); end
    tick();
    fetch(32'h100, 32'h0010_0093, 1'b0);
    @(negedge clk);
    total++; if ({m_valid, inst, inst_pc, inst_err} !== {1'b1, 32'h0010_0093, 32'h100, 2'd0}) begin bad++; $display("FAIL fl_next: got %b/%h/%h/%0d want 1/00100093/100/0", m_valid, inst, inst_pc, inst_err); end
    pop_one();
  endtask

  task automatic test_async_reset();
    pc = 32'hA; s_valid = 1'b1;
    tick();
    pc = 32'h600;
    tick();
    s_valid = 1'b0; mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    @(negedge clk);
    total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL ar_setup: got %b want 1", m_valid); end
    #2 rst = 1'b1;
    #1;
    total++; if ({m_valid, mem_req_valid, inst_err} !== 4'b0000) begin bad++; $display("FAIL ar_immediate: got %b/%b/%0d want 0/0/0", m_valid, mem_req_valid, inst_err); end
    tick();
    rst = 1'b0;
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h777;
    tick();
    mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    @(negedge clk);
    total++; if (m_valid !== 1'b0 || s_ready !== 1'b1) begin bad++; $display("FAIL ar_stray: got m_valid=%b s_ready=%b want 0/1", m_valid, s_ready); end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_misaligned();
    test_fault();
    test_timeout();
    test_flush_wait();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
